// File: rtl/muldiv_iter.sv
// muldiv_iter
//   Multi-cycle multiply/divide unit for the EX stage. It handles MULT, MULTU,
//   DIV, DIVU, MADD, MADDU, MSUB and MSUBU through a start/busy/done handshake.
//   The result is a 2*WIDTH-bit {HI, LO} value. For divides this value is
//   {remainder, quotient}.
//   Multiplies take MUL_CYCLES cycles and can accumulate into HI/LO.
//   Divides use a radix-2 restoring divider with one quotient bit per cycle.
//   A divide is followed by one sign-fix cycle.
//
// Ports
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset
//   flush   in   aborts any operation in flight; no done, result untouched
//   start   in   request, accepted only while busy is low
//   op      in   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU
//   op1     in   rs operand (dividend / multiplicand)
//   op2     in   rt operand (divisor / multiplier)
//   hilo_i  in   current {HI, LO}, used by the accumulate ops
//   busy    out  operation in flight (including the done cycle)
//   done    out  one-cycle pulse; result is valid
//   result  out  {HI, LO}; holds until the next accepted operation completes
module muldiv_iter #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   op1,
  input  logic [WIDTH-1:0]   op2,
  input  logic [2*WIDTH-1:0] hilo_i,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH + MUL_CYCLES + 1);
  localparam logic [CW-1:0]    CNT_ONE = CW'(1);
  localparam logic [CW-1:0]    CNT_ZERO = '0;
  localparam logic [WIDTH-1:0] ZERO_W = '0;

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic [2:0]           op_q;
  logic [WIDTH-1:0]     absA_q;
  logic [WIDTH-1:0]     absB_q;
  logic                 signA_q;
  logic                 signB_q;
  logic                 divZero_q;
  logic [2*WIDTH-1:0]   hilo_q;
  logic [WIDTH-1:0]     rem_q;
  logic [WIDTH-1:0]     quo_q;
  logic [2*WIDTH-1:0]   result_q;
  logic                 done_q;

  // Operand conditioning at accept time. Bit 0 of op marks the unsigned
  // variants. The divide ops are 2 and 3.
  logic             opSigned;
  logic             opIsDiv;
  logic             opDivZero;
  logic [WIDTH-1:0] absOp1;
  logic [WIDTH-1:0] absOp2;

  assign opSigned  = ~op[0];
  assign opIsDiv   = (op[2:1] == 2'b01);
  assign opDivZero = (op2 == ZERO_W);
  assign absOp1    = (opSigned && op1[WIDTH-1]) ? -op1 : op1;
  assign absOp2    = (opSigned && op2[WIDTH-1]) ? -op2 : op2;

  // Datapath evaluated from the latched operands only, so later input
  // changes cannot disturb an operation in flight.
  logic               latchedSigned;
  logic               signsDiffer;
  logic [2*WIDTH-1:0] product_d;
  logic [2*WIDTH-1:0] signedProd_d;
  logic [2*WIDTH-1:0] mulResult_d;
  logic [WIDTH:0]     shifted_d;
  logic [WIDTH:0]     trial_d;
  logic [WIDTH-1:0]   quoFix_d;
  logic [WIDTH-1:0]   remFix_d;
  logic [2*WIDTH-1:0] divResult_d;

  assign latchedSigned = ~op_q[0];
  assign signsDiffer   = latchedSigned && (signA_q ^ signB_q);
  assign product_d     = {ZERO_W, absA_q} * {ZERO_W, absB_q};
  assign signedProd_d  = signsDiffer ? -product_d : product_d;

  // op bit 2 selects accumulate. Bit 1 then selects subtract.
  assign mulResult_d = !op_q[2] ? signedProd_d :
                       (op_q[1] ? hilo_q - signedProd_d : hilo_q + signedProd_d);

  // One restoring step. The next dividend bit is shifted into the partial
  // remainder, and the subtraction is kept only if it did not go negative.
  assign shifted_d = {rem_q, quo_q[WIDTH-1]};
  assign trial_d   = shifted_d - {1'b0, absB_q};

  // The most-negative / -1 case wraps to itself naturally, so it needs no
  // dedicated handling.
  assign quoFix_d = signsDiffer ? -quo_q : quo_q;
  assign remFix_d = (latchedSigned && signA_q) ? -rem_q : rem_q;

  // On divide by zero, quo_q was loaded with the raw op1. That value is
  // returned as the remainder.
  assign divResult_d = divZero_q ? {quo_q, ~ZERO_W} : {remFix_d, quoFix_d};

  // Control FSM. Flush has priority over everything except reset.
  // result and done are registered on the edge that enters DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= CNT_ZERO;
      op_q      <= 3'd0;
      absA_q    <= '0;
      absB_q    <= '0;
      signA_q   <= 1'b0;
      signB_q   <= 1'b0;
      divZero_q <= 1'b0;
      hilo_q    <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
    end else if (flush) begin
      state_q <= IDLE;
      cnt_q   <= CNT_ZERO;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            op_q      <= op;
            absA_q    <= absOp1;
            absB_q    <= absOp2;
            signA_q   <= op1[WIDTH-1];
            signB_q   <= op2[WIDTH-1];
            hilo_q    <= hilo_i;
            divZero_q <= opIsDiv && opDivZero;
            rem_q     <= '0;
            quo_q     <= opDivZero ? op1 : absOp1;
            if (opIsDiv) begin
              cnt_q   <= CW'(WIDTH - 1);
              state_q <= opDivZero ? FIX : DIV;
            end else begin
              cnt_q   <= CW'(MUL_CYCLES - 1);
              state_q <= MUL;
            end
          end
        end
        MUL: begin
          if (cnt_q == CNT_ZERO) begin
            result_q <= mulResult_d;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        DIV: begin
          if (!trial_d[WIDTH]) begin
            rem_q <= trial_d[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_q <= shifted_d[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], 1'b0};
          end
          if (cnt_q == CNT_ZERO) begin
            state_q <= FIX;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        FIX: begin
          result_q <= divResult_d;
          done_q   <= 1'b1;
          state_q  <= DONE;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign result = result_q;

endmodule
